// File: rtl/down_count_timer_pkg.sv
// Shared types and constants for the down_count_timer block.
package down_count_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [DEFAULT_WIDTH-1:0] ZERO = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/down_count_timer.sv
// Programmable down-counting timer with pause, abort and a one-cycle done pulse.
// Define DOWN_COUNT_TIMER_AUTORELOAD_EN to make runs repeat from the reload value.
module down_count_timer
  import down_count_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO_Q = WIDTH'(ZERO);
  localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] q_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] q_dec;

`ifdef DOWN_COUNT_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_reg;
`endif

  assign q_dec = q_reg - ONE_Q;

  // Priority at each edge: RST, abort, start, pause, decrement.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg     <= ZERO_Q;
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef DOWN_COUNT_TIMER_AUTORELOAD_EN
      reload_reg <= ZERO_Q;
`endif
    end else if (abort) begin
      q_reg     <= ZERO_Q;
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (start) begin
      q_reg    <= load_val;
      done_reg <= (load_val == ZERO_Q);
`ifdef DOWN_COUNT_TIMER_AUTORELOAD_EN
      // A zero load still runs: it completes on every unpaused cycle.
      reload_reg <= load_val;
      state_reg  <= RUN;
      busy_reg   <= 1'b1;
`else
      if (load_val == ZERO_Q) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        state_reg <= RUN;
        busy_reg  <= 1'b1;
      end
`endif
    end else begin
      case (state_reg)
        RUN: begin
          if (pause) begin
            done_reg <= 1'b0;
          end else begin
`ifdef DOWN_COUNT_TIMER_AUTORELOAD_EN
            // The q=0 cycle is part of the period, so the reload happens one edge later.
            if (q_reg == ZERO_Q) begin
              q_reg    <= reload_reg;
              done_reg <= (reload_reg == ZERO_Q);
            end else begin
              q_reg    <= q_dec;
              done_reg <= (q_dec == ZERO_Q);
            end
`else
            q_reg    <= q_dec;
            done_reg <= (q_dec == ZERO_Q);
            if (q_dec == ZERO_Q) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
`endif
          end
        end
        default: begin
          done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign q    = q_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule
